uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 57600, line rate in baud.
REQ-003 Parameter DATA_BITS, default 8, payload bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits checked; legal 1 or 2.
REQ-006 Localparam TICK_DIV = CLK_FREQ/(BAUD_RATE*16), clocks per oversample tick (54 at defaults); TICK_DIV >= 2 required.
REQ-007 clk  input  1  system clock.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 rx  input  1  asynchronous serial line, idle high.
REQ-010 data  output  DATA_BITS  received payload, LSB first on line.
REQ-011 valid  output  1  data/status held and valid.
REQ-012 ready  input  1  consumer accepts when valid && ready.
REQ-013 parity_err  output  1  parity mismatch for held frame (0 when PARITY=0).
REQ-014 frame_err  output  1  any stop bit sampled low for held frame.
REQ-015 overrun  output  1  one-cycle pulse: frame completed while valid && !ready; frame dropped.
REQ-016 busy  output  1  high in every state other than IDLE.

Function
REQ-017 rx passes a 2-flop synchronizer reset to 1; all logic uses the synchronized value rxs.
REQ-018 Prescaler counts 0..TICK_DIV-1 and emits tick at TICK_DIV-1; prescaler and sample counter s (0..15) clear on start detection.
REQ-019 States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-020 IDLE -> START on rxs 1->0 transition.
REQ-021 In each bit, rxs is sampled on ticks at s=7,8,9; bit value = majority of three, decided at s=9 tick; bit ends at s=15 tick.
REQ-022 START: majority 1 -> false start, return to IDLE with no output; majority 0 -> DATA at bit end.
REQ-023 DATA: DATA_BITS bits shifted in LSB first, then PAR if PARITY!=0 else STOP.
REQ-024 PAR: even mode error if XOR(data, parity bit)=1; odd mode error if XOR=0.
REQ-025 STOP: STOP_BITS bits checked; frame_err set if any stop majority is 0.
REQ-026 Frame completes at the s=9 decision of the last stop bit; state -> IDLE if that bit was 1, else WAIT_HIGH.
REQ-027 WAIT_HIGH -> IDLE only when rxs=1 (break/stuck-low line produces exactly one frame).
REQ-028 On completion with valid=0, or valid=1 && ready=1 same cycle, data/parity_err/frame_err load and valid=1 next cycle (latency 1 clock after decision).
REQ-029 On completion with valid=1 && ready=0: held outputs unchanged, overrun=1 for one cycle, new frame discarded.
REQ-030 valid clears the cycle after valid && ready when no new frame loads; data and error flags hold until next load.
REQ-031 Frames with parity_err or frame_err are still delivered via valid.

Reset
REQ-032 rst_n low at any time, including mid-frame: state IDLE, counters 0, synchronizer 1, data 0, valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-033 After rst_n deasserts, no frame is started until a 1->0 transition of rxs.

Verification (bench: CLK_FREQ=64*BAUD_RATE -> TICK_DIV=4, 64 clocks/bit)
REQ-034 8N1 frame 0xA5, ready=1, one-clock glitch at s=8 of bit 3 -> valid one cycle, data=0xA5, both errors 0.
REQ-035 PARITY=1, frame 0x03 with parity bit 1 -> data=0x03, parity_err=1; same with parity bit 0 -> parity_err=0.
REQ-036 Stop bit 0 then rx held low 20 bit-times -> one frame, data=0x00, frame_err=1; no further valid until rx high and a new start edge.
REQ-037 rx low for 20 clocks then high -> false start, no valid, busy back to 0 within 1 bit-time.
REQ-038 ready=0, frames 0x11 then 0x22 -> data stays 0x11, overrun pulses once at 0x22 completion; ready=1 -> 0x11 accepted, valid clears.
REQ-039 rst_n low mid-data of 0x77, release, send 0x5A -> all outputs 0 during reset, then data=0x5A, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 16x oversampling, 3-sample majority vote,
// optional parity, 1/2 stop bits, single held output register with overrun flag.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 57600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * 16);
  localparam int PW       = $clog2(TICK_DIV);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;

  state_t               state;
  logic                 rx_meta, rxs, rxs_d;
  logic [PW-1:0]        pcnt;
  logic [3:0]           s;
  logic [1:0]           samp;
  logic [3:0]           bitn;
  logic                 stopn;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr_q, ferr_q;
  logic                 tick, decide, bit_end, maj, last_stop, done;

  assign tick      = (pcnt == PW'(TICK_DIV - 1));
  assign decide    = tick && (s == 4'd9);
  assign bit_end   = tick && (s == 4'd15);
  // s=7 and s=8 samples are registered; the s=9 sample is the live rxs
  assign maj       = (samp[0] & samp[1]) | (samp[0] & rxs) | (samp[1] & rxs);
  assign last_stop = (stopn == 1'(STOP_BITS - 1));
  assign done      = (state == STOP) && decide && last_stop;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      rxs_d      <= 1'b1;
      state      <= IDLE;
      pcnt       <= '0;
      s          <= '0;
      samp       <= '0;
      bitn       <= '0;
      stopn      <= 1'b0;
      shreg      <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      overrun <= 1'b0;

      if (state == IDLE || state == WAIT_HIGH) begin
        pcnt <= '0;
        s    <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + PW'(1);
        if (tick) s <= s + 4'd1;
      end
      if (tick && s == 4'd7) samp[0] <= rxs;
      if (tick && s == 4'd8) samp[1] <= rxs;

      case (state)
        IDLE: if (rxs_d && !rxs) begin
          state <= START;
          pcnt  <= '0;
          s     <= '0;
        end
        START: begin
          if (decide && maj) state <= IDLE;
          else if (bit_end) begin
            state  <= DATA;
            bitn   <= '0;
            stopn  <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
          end
        end
        DATA: begin
          if (decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            bitn <= bitn + 4'd1;
            if (bitn == 4'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: begin
          if (decide) perr_q <= (PARITY == 2) ? ~(^shreg ^ maj) : (^shreg ^ maj);
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (decide) begin
            ferr_q <= ferr_q | ~maj;
            if (last_stop) state <= maj ? IDLE : WAIT_HIGH;
          end
          if (bit_end) stopn <= stopn + 1'b1;
        end
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase

      // A completing frame either lands in the holding register or is dropped
      if (done) begin
        if (!valid || ready) begin
          data       <= shreg;
          parity_err <= (PARITY != 0) && perr_q;
          frame_err  <= ferr_q | ~maj;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: one 8N1 and one 8E1 instance at 64 clocks per bit.
module tb_uart_rx_param;
  localparam int BAUD = 1_000_000;
  localparam int CLKF = 64 * BAUD;
  localparam int BITC = 64;

  logic clk = 1'b0, rst_n = 1'b0;
  logic rx_n = 1'b1, ready_n = 1'b1, rx_p = 1'b1, ready_p = 1'b1;
  logic [7:0] data_n, data_p;
  logic valid_n, perr_n, ferr_n, ovr_n, busy_n;
  logic valid_p, perr_p, ferr_p, ovr_p, busy_p;

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst_n(rst_n), .rx(rx_n), .ready(ready_n), .data(data_n), .valid(valid_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n), .busy(busy_n));

  uart_rx_param #(.CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .ready(ready_p), .data(data_p), .valid(valid_p),
    .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int vcnt_n = 0, ocnt_n = 0;
  logic [9:0] q_n[$], q_p[$];

  // Handshake monitor: inputs change at negedge, so negedge+1 sees what the next posedge sees
  always begin
    @(negedge clk); #1;
    if (valid_n) vcnt_n++;
    if (ovr_n) ocnt_n++;
    if (valid_n && ready_n) q_n.push_back({perr_n, ferr_n, data_n});
    if (valid_p && ready_p) q_p.push_back({perr_p, ferr_p, data_p});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic b);
    if (sel) rx_p = b; else rx_n = b;
  endtask

  task automatic send_bit(input bit sel, input logic b, input bit glitch);
    for (int i = 0; i < BITC; i++) begin
      @(negedge clk);
      drive(sel, (glitch && i == 36) ? ~b : b);
    end
  endtask

  task automatic idle(input bit sel, input int nbits);
    drive(sel, 1'b1);
    repeat (nbits * BITC) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic pb, input logic stop, input int glitch_bit);
    send_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i], glitch_bit == i);
    if (use_par) send_bit(sel, pb, 1'b0);
    send_bit(sel, stop, 1'b0);
  endtask

  task automatic expect_frame(input bit sel, input string name, input logic [9:0] exp);
    int sz;
    logic [9:0] got;
    sz = sel ? q_p.size() : q_n.size();
    chk({name, "_count"}, sz, 1);
    if (sz > 0) begin
      got = sel ? q_p.pop_front() : q_n.pop_front();
      chk(name, got, exp);
    end
    if (sel) q_p.delete(); else q_n.delete();
  endtask

  typedef struct {
    logic [7:0] d;
    logic       pb;
    logic       stop;
    logic [9:0] exp;  // {parity_err, frame_err, data}
  } vec_t;
  vec_t tbl[6];

  initial begin
    int v0, o0;
    logic [7:0] rd;
    logic rpb, rst;

    tbl[0] = '{8'h03, 1'b1, 1'b1, 10'h203};
    tbl[1] = '{8'h03, 1'b0, 1'b1, 10'h003};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 10'h001};
    tbl[3] = '{8'h01, 1'b0, 1'b1, 10'h201};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 10'h0FF};
    tbl[5] = '{8'h80, 1'b0, 1'b0, 10'h380};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outputs_n", {data_n, valid_n, perr_n, ferr_n, ovr_n, busy_n}, 0);
    chk("rst_outputs_p", {data_p, valid_p, perr_p, ferr_p, ovr_p, busy_p}, 0);
    rst_n = 1'b1;
    repeat (BITC) @(negedge clk);
    chk("no_start_after_reset", {valid_n, busy_n, valid_p, busy_p}, 0);

    // 0xA5 with a one-clock glitch inside data bit 3
    v0 = vcnt_n;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 3);
    idle(1'b0, 2);
    chk("glitch_valid_cycles", vcnt_n - v0, 1);
    expect_frame(1'b0, "glitch_a5", 10'h0A5);

    // Parity / framing table on the even-parity instance
    foreach (tbl[i]) begin
      send_frame(1'b1, tbl[i].d, 1'b1, tbl[i].pb, tbl[i].stop, -1);
      idle(1'b1, 2);
      expect_frame(1'b1, $sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Stop bit low then line stuck low: exactly one frame
    v0 = vcnt_n;
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, -1);
    repeat (20 * BITC) @(negedge clk);
    chk("break_valid_cycles", vcnt_n - v0, 1);
    chk("break_busy_low_line", busy_n, 1);
    expect_frame(1'b0, "break_frame", 10'h100);
    idle(1'b0, 3);
    chk("break_no_more_frames", q_n.size(), 0);
    chk("break_idle_busy", busy_n, 0);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
    idle(1'b0, 2);
    expect_frame(1'b0, "after_break", 10'h03C);

    // False start: 20 clocks low
    v0 = vcnt_n;
    @(negedge clk); rx_n = 1'b0;
    repeat (10) @(negedge clk);
    chk("false_start_busy", busy_n, 1);
    repeat (10) @(negedge clk); rx_n = 1'b1;
    repeat (BITC - 20) @(negedge clk);
    chk("false_start_idle", busy_n, 0);
    chk("false_start_no_valid", vcnt_n - v0, 0);

    // Overrun: ready low across two frames
    @(negedge clk); ready_n = 1'b0;
    o0 = ocnt_n;
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    idle(1'b0, 1);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
    idle(1'b0, 1);
    chk("ovr_pulses", ocnt_n - o0, 1);
    chk("ovr_held", {valid_n, data_n}, {1'b1, 8'h11});
    @(negedge clk); ready_n = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", valid_n, 0);
    expect_frame(1'b0, "ovr_accepted", 10'h011);

    // Reset in the middle of 0x77
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1, 1'b0);
    chk("mid_frame_busy", busy_n, 1);
    @(negedge clk); rst_n = 1'b0; #1;
    chk("mid_rst_outputs", {data_n, valid_n, perr_n, ferr_n, ovr_n, busy_n}, 0);
    rx_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b0, 2);
    chk("mid_rst_dropped", q_n.size(), 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
    idle(1'b0, 2);
    expect_frame(1'b0, "post_rst_5a", 10'h05A);

    // Randomised frames against the reference rules
    for (int k = 0; k < 10; k++) begin
      rd = 8'($urandom);
      send_frame(1'b0, rd, 1'b0, 1'b0, 1'b1, $urandom_range(0, 12) - 2);
      idle(1'b0, $urandom_range(1, 3));
      expect_frame(1'b0, $sformatf("rand_n%0d", k), {2'b00, rd});
    end
    for (int k = 0; k < 10; k++) begin
      rd  = 8'($urandom);
      rpb = 1'($urandom);
      rst = ($urandom_range(0, 3) != 0);
      send_frame(1'b1, rd, 1'b1, rpb, rst, -1);
      idle(1'b1, $urandom_range(1, 3));
      expect_frame(1'b1, $sformatf("rand_p%0d", k), {(^rd) ^ rpb, ~rst, rd});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
